// File: rtl/reflet_vga_capture_interface.sv
// -----------------------------------------------------------------------------
// reflet_vga_capture_interface
//
// Memory-mapped VGA frame-capture peripheral. It samples an external 6-bit
// (2R/2G/2B) VGA stream with active-low h_sync/v_sync. The stream is
// downscaled by pixel_clocks horizontally and by line_skip vertically into an
// h_pixels x v_pixels framebuffer. The CPU reads the framebuffer back through
// four 8-bit registers.
//
// Register map (offset from base_addr):
//   0  H      RW  pixel column to read
//   1  V      RW  pixel row to read
//   2  PIXEL  RO  {2'b00, B, G, R} of framebuffer[V][H], 0 when out of range
//   3  CTRL   RW  write: bit0 arm, bit1 clear DONE, bit2 clear ABORT
//                 read : {5'b0, ABORT, DONE, BUSY}
//
// Ports:
//   clk       system clock
//   reset     synchronous, active-high reset
//   enable    bus enable
//   addr      bus address (base_addr_size bits)
//   data_in   bus write data
//   data_out  bus read data, 0 when the block is not selected
//   write_en  bus write strobe
//   h_sync    VGA horizontal sync, active low, asynchronous to clk
//   v_sync    VGA vertical sync, active low, asynchronous to clk
//   R_in      red   (2 bits)
//   G_in      green (2 bits)
//   B_in      blue  (2 bits)
//   interrupt (only with REFLET_VGA_CAPTURE_IRQ_EN) one-clk pulse when DONE sets
//
// Optional feature macro: REFLET_VGA_CAPTURE_IRQ_EN adds the interrupt output.
// -----------------------------------------------------------------------------
module reflet_vga_capture_interface #(
  parameter int                        base_addr_size = 16,
  parameter logic [base_addr_size-1:0] base_addr      = 16'hFF28,
  parameter int                        h_pixels       = 160,
  parameter int                        v_pixels       = 120,
  parameter int                        pixel_clocks   = 4,
  parameter int                        h_active_start = 6,
  parameter int                        v_active_start = 33,
  parameter int                        line_skip      = 4,
  parameter bit                        mem_resetable  = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [base_addr_size-1:0] addr,
  input  logic [7:0]                data_in,
  output logic [7:0]                data_out,
  input  logic                      write_en,
  input  logic                      h_sync,
  input  logic                      v_sync,
  input  logic [1:0]                R_in,
  input  logic [1:0]                G_in,
  input  logic [1:0]                B_in
`ifdef REFLET_VGA_CAPTURE_IRQ_EN
  ,
  output logic                      interrupt
`endif
);

  // ---------------------------------------------------------------------------
  // Derived sizes
  // ---------------------------------------------------------------------------
  localparam int DEPTH     = h_pixels * v_pixels;
  localparam int MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Last cycle-counter value of interest: one column pitch past the final
  // sample point. The counter parks here on overlong lines.
  localparam int CYC_MAX_I = h_active_start + h_pixels * pixel_clocks + pixel_clocks / 2;
  localparam int CYC_W     = $clog2(CYC_MAX_I + 1);
  localparam int COL_W     = $clog2(h_pixels + 1);
  localparam int ROW_W     = $clog2(v_pixels + 1);
  localparam int LINE_W    = $clog2(v_active_start + 1);
  localparam int PH_W      = $clog2(line_skip + 1);

  localparam logic [CYC_W-1:0]  CYC_MAX      = CYC_W'(CYC_MAX_I);
  localparam logic [CYC_W-1:0]  FIRST_SAMPLE = CYC_W'(h_active_start + pixel_clocks / 2);
  localparam logic [CYC_W-1:0]  PCLK         = CYC_W'(pixel_clocks);
  localparam logic [COL_W-1:0]  COL_END      = COL_W'(h_pixels);
  localparam logic [ROW_W-1:0]  ROW_LAST     = ROW_W'(v_pixels - 1);
  localparam logic [LINE_W-1:0] LINE_LAST    = LINE_W'(v_active_start - 1);
  localparam logic [PH_W-1:0]   PH_LAST      = PH_W'(line_skip - 1);
  localparam logic [MEM_AW-1:0] H_PIX_A      = MEM_AW'(h_pixels);

  localparam logic [base_addr_size:0] ADDR_LO = {1'b0, base_addr};
  localparam logic [base_addr_size:0] ADDR_HI = {1'b0, base_addr} + (base_addr_size + 1)'(3);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRAME,
    BACK,
    ACTIVE,
    DONE_ST
  } state_t;

  state_t state_q, state_d;

  // ---------------------------------------------------------------------------
  // Input synchronisers and edge detectors
  // ---------------------------------------------------------------------------
  logic [1:0] h_sr, v_sr;
  logic [5:0] rgb_s1, rgb_s2;
  logic       h_prev, v_prev;
  logic       h_s, v_s;
  logic       h_rise, v_rise, v_fall;
  logic [5:0] rgb_s;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the
  // two-flop synchroniser into a single stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      // Syncs idle high, so park the chain high to avoid a false edge.
      h_sr   <= 2'b11;
      v_sr   <= 2'b11;
      h_prev <= 1'b1;
      v_prev <= 1'b1;
      rgb_s1 <= '0;
      rgb_s2 <= '0;
    end else begin
      h_sr   <= {h_sr[0], h_sync};
      v_sr   <= {v_sr[0], v_sync};
      h_prev <= h_sr[1];
      v_prev <= v_sr[1];
      rgb_s1 <= {B_in, G_in, R_in};
      rgb_s2 <= rgb_s1;
    end
  end

  assign h_s    = h_sr[1];
  assign v_s    = v_sr[1];
  assign rgb_s  = rgb_s2;
  // Rising edge of an active-low sync marks the end of the pulse.
  assign h_rise = h_s & ~h_prev;
  assign v_rise = v_s & ~v_prev;
  assign v_fall = ~v_s & v_prev;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic       sel, wr, ctrl_wr, arm;
  logic [1:0] offset;

  assign sel     = enable && ({1'b0, addr} >= ADDR_LO) && ({1'b0, addr} <= ADDR_HI);
  // Only the low two bits of (addr - base_addr) matter inside the window.
  assign offset  = addr[1:0] - base_addr[1:0];
  assign wr      = sel && write_en;
  assign ctrl_wr = wr && (offset == 2'd3);
  assign arm     = ctrl_wr && data_in[0];

  // ---------------------------------------------------------------------------
  // Capture counters
  // ---------------------------------------------------------------------------
  logic [CYC_W-1:0]  cyc_q, target_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic [LINE_W-1:0] line_q;
  logic [PH_W-1:0]   phase_q;
  logic              capture_line;
  logic              cap_we;
  logic [MEM_AW-1:0] cap_addr;

  assign capture_line = (phase_q == '0);
  // target_q walks the sample points h_active_start + c*pixel_clocks +
  // pixel_clocks/2 so no divider is needed to recover the column.
  assign cap_we   = !reset && (state_q == ACTIVE) && capture_line && !h_rise &&
                    (col_q < COL_END) && (cyc_q == target_q);
  assign cap_addr = MEM_AW'(row_q) * H_PIX_A + MEM_AW'(col_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q    <= CYC_MAX;
      target_q <= FIRST_SAMPLE;
      col_q    <= COL_END;
      row_q    <= '0;
      line_q   <= '0;
      phase_q  <= '0;
    end else begin
      // Saturating cycle counter, restarted by every h_sync rising edge.
      if (h_rise) begin
        cyc_q <= '0;
      end else if (cyc_q != CYC_MAX) begin
        cyc_q <= cyc_q + 1'b1;
      end

      if (h_rise) begin
        col_q    <= '0;
        target_q <= FIRST_SAMPLE;
      end else if (cap_we) begin
        col_q    <= col_q + 1'b1;
        target_q <= target_q + PCLK;
      end

      case (state_q)
        WAIT_FRAME: begin
          if (v_rise) line_q <= '0;
        end
        BACK: begin
          if (h_rise && !v_fall) begin
            line_q  <= line_q + 1'b1;
            phase_q <= '0;
            row_q   <= '0;
          end
        end
        ACTIVE: begin
          // An h_sync edge closes the current line; a capture line
          // advances the framebuffer row.
          if (h_rise && !v_fall) begin
            phase_q <= (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
            if (capture_line) row_q <= row_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: the default assigned first gives state_d a value on every path,
  // so no latch is inferred for combinational outputs.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (arm) state_d = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (v_rise) state_d = BACK;
      end
      BACK: begin
        if (v_fall)                             state_d = WAIT_FRAME;
        else if (h_rise && line_q == LINE_LAST) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (v_fall)                                          state_d = WAIT_FRAME;
        else if (h_rise && capture_line && row_q == ROW_LAST) state_d = DONE_ST;
      end
      DONE_ST: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic busy;
  logic done_q, abort_q;

  assign busy = (state_q == WAIT_FRAME) || (state_q == BACK) || (state_q == ACTIVE);

  always_ff @(posedge clk) begin
    if (reset) begin
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      // Hardware set takes priority over a simultaneous software clear.
      if (ctrl_wr && data_in[1]) done_q <= 1'b0;
      if (state_q == DONE_ST)    done_q <= 1'b1;
      if (ctrl_wr && data_in[2]) abort_q <= 1'b0;
      if (((state_q == BACK) || (state_q == ACTIVE)) && v_fall) abort_q <= 1'b1;
    end
  end

`ifdef REFLET_VGA_CAPTURE_IRQ_EN
  // Registered alongside done_q, so the pulse lines up with DONE rising.
  always_ff @(posedge clk) begin
    if (reset) interrupt <= 1'b0;
    else       interrupt <= (state_q == DONE_ST);
  end
`endif

  // ---------------------------------------------------------------------------
  // H / V registers
  // ---------------------------------------------------------------------------
  logic [7:0] h_reg, v_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      h_reg <= '0;
      v_reg <= '0;
    end else begin
      if (wr && offset == 2'd0) h_reg <= data_in;
      if (wr && offset == 2'd1) v_reg <= data_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Framebuffer: one capture write port, one bus read port
  // ---------------------------------------------------------------------------
  logic [5:0]        mem [DEPTH];
  logic [5:0]        pixel_q;
  logic              rd_in_range;
  logic [MEM_AW-1:0] rd_addr;

  generate
    if (mem_resetable) begin : g_mem_rst
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (cap_we) begin
          mem[cap_addr] <= rgb_s;
        end
      end
    end else begin : g_mem_norst
      // NOTE: the array is deliberately left out of reset; a reset term
      // would stop it mapping onto block RAM and is not needed since the
      // contents are only meaningful after a capture.
      always_ff @(posedge clk) begin
        if (cap_we) mem[cap_addr] <= rgb_s;
      end
    end
  endgenerate

  assign rd_in_range = (int'(h_reg) < h_pixels) && (int'(v_reg) < v_pixels);
  assign rd_addr     = MEM_AW'(v_reg) * H_PIX_A + MEM_AW'(h_reg);

  // Read every clock from the registered H/V, so PIXEL follows a new
  // coordinate one cycle after it is written.
  always_ff @(posedge clk) begin
    if (reset)            pixel_q <= '0;
    else if (rd_in_range) pixel_q <= mem[rd_addr];
    else                  pixel_q <= '0;
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    data_out = '0;
    if (sel) begin
      case (offset)
        2'd0:    data_out = h_reg;
        2'd1:    data_out = v_reg;
        2'd2:    data_out = {2'b00, pixel_q};
        default: data_out = {5'b0, abort_q, done_q, busy};
      endcase
    end
  end

endmodule

// File: tb/tb_reflet_vga_capture_interface.sv
// -----------------------------------------------------------------------------
// tb_reflet_vga_capture_interface
//
// Directed bench for the VGA capture peripheral with a small 8x4 framebuffer.
// The source image encodes position: for active line l and column c the
// pixel {B,G,R} is {l[1:0], l[2], c[2:0]}, XORed with a per-frame pattern.
// Captured rows come from lines 0,4,8,12, so B is always 0 there unless the
// pattern sets it, and G[1] tells odd rows from even ones.
// -----------------------------------------------------------------------------
module tb_reflet_vga_capture_interface;

  localparam int          H_PIX = 8;
  localparam logic [15:0] A_H   = 16'hFF28;
  localparam logic [15:0] A_V   = 16'hFF29;
  localparam logic [15:0] A_PIX = 16'hFF2A;
  localparam logic [15:0] A_CTL = 16'hFF2B;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0]  data_in = '0;
  logic [7:0]  data_out;
  logic        write_en = 1'b0;
  logic        h_sync = 1'b1;
  logic        v_sync = 1'b1;
  logic [1:0]  R_in = '0;
  logic [1:0]  G_in = '0;
  logic [1:0]  B_in = '0;

  int checks = 0;
  int errors = 0;

`ifdef REFLET_VGA_CAPTURE_IRQ_EN
  logic interrupt;
  logic irq_prev = 1'b0;
  int   irq_hi   = 0;
  int   irq_rise = 0;

  always @(negedge clk) begin
    if (interrupt) irq_hi++;
    if (interrupt && !irq_prev) irq_rise++;
    irq_prev = interrupt;
  end
`endif

  reflet_vga_capture_interface #(
    .base_addr_size(16),
    .base_addr     (16'hFF28),
    .h_pixels      (8),
    .v_pixels      (4),
    .pixel_clocks  (4),
    .h_active_start(6),
    .v_active_start(3),
    .line_skip     (4),
    .mem_resetable (1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .write_en (write_en),
    .h_sync   (h_sync),
    .v_sync   (v_sync),
    .R_in     (R_in),
    .G_in     (G_in),
    .B_in     (B_in)
`ifdef REFLET_VGA_CAPTURE_IRQ_EN
    ,
    .interrupt(interrupt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, observed, expected);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    enable   = 1'b1;
    addr     = a;
    data_in  = d;
    write_en = 1'b1;
    tick();
    enable   = 1'b0;
    write_en = 1'b0;
  endtask

  task automatic check_reg(input logic [15:0] a, input logic [7:0] expected, input string tag);
    enable   = 1'b1;
    addr     = a;
    write_en = 1'b0;
    #2;
    check(tag, data_out, expected);
    tick();
    enable = 1'b0;
  endtask

  task automatic check_pixel(input logic [7:0] h, input logic [7:0] v,
                             input logic [7:0] expected, input string tag);
    bus_write(A_H, h);
    bus_write(A_V, v);
    tick();
    check_reg(A_PIX, expected, tag);
  endtask

  function automatic logic [5:0] pix(input int l, input int c);
    logic [7:0] lv;
    logic [7:0] cv;
    lv = l[7:0];
    cv = c[7:0];
    return {lv[1:0], lv[2], cv[2:0]};
  endfunction

  task automatic set_rgb(input logic [5:0] v);
    {B_in, G_in, R_in} = v;
  endtask

  // One source line: 4-clock h_sync pulse, 7 clocks of lead-in, then ncols
  // columns of 4 clocks each. The capture sample lands inside each column.
  task automatic vga_line(input int l, input logic [5:0] pat, input bit active, input int ncols);
    h_sync = 1'b0;
    set_rgb(6'h00);
    repeat (4) tick();
    h_sync = 1'b1;
    repeat (7) tick();
    for (int c = 0; c < ncols; c++) begin
      set_rgb(active ? (pix(l, c) ^ pat) : 6'h00);
      repeat (4) tick();
    end
    set_rgb(6'h00);
    if (ncols == H_PIX) repeat (4) tick();
  endtask

  task automatic vsync_line();
    v_sync = 1'b0;
    vga_line(0, 6'h00, 1'b0, H_PIX);
    v_sync = 1'b1;
  endtask

  task automatic back_porch();
    vga_line(0, 6'h00, 1'b0, H_PIX);
    vga_line(0, 6'h00, 1'b0, H_PIX);
  endtask

  task automatic active_lines(input int first, input int last, input logic [5:0] pat);
    for (int l = first; l <= last; l++) vga_line(l, pat, 1'b1, H_PIX);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // 1. Reset values and address window edges.
    check_reg(A_H,      8'h00, "rst_h");
    check_reg(A_V,      8'h00, "rst_v");
    check_reg(A_PIX,    8'h00, "rst_pixel");
    check_reg(A_CTL,    8'h00, "rst_ctrl");
    check_reg(16'hFF2C, 8'h00, "above_window");
    check_reg(16'hFF27, 8'h00, "below_window");

    // 2. Full frame, pattern 0.
    bus_write(A_CTL, 8'h01);
    check_reg(A_CTL, 8'h01, "armed_busy");
    vsync_line();
    back_porch();
    active_lines(0, 5, 6'h00);
    check_reg(A_CTL, 8'h01, "busy_mid_frame");
    active_lines(6, 13, 6'h00);
    check_reg(A_CTL, 8'h02, "frame_done");
`ifdef REFLET_VGA_CAPTURE_IRQ_EN
    check("irq_hi_1", 8'(irq_hi), 8'd1);
    check("irq_rise_1", 8'(irq_rise), 8'd1);
`endif
    check_pixel(8'd5, 8'd2, 8'h05, "pix_5_2");
    check_reg(A_H, 8'h05, "h_readback");
    check_pixel(8'd5, 8'd1, 8'h0D, "pix_5_1");
    check_pixel(8'd0, 8'd3, 8'h08, "pix_0_3");
    check_pixel(8'd7, 8'd0, 8'h07, "pix_7_0");

    // 3. Abort after two captured rows, then a full frame.
    bus_write(A_CTL, 8'h02);
    check_reg(A_CTL, 8'h00, "done_cleared");
    bus_write(A_CTL, 8'h01);
    vsync_line();
    back_porch();
    active_lines(0, 4, 6'h30);
    vsync_line();
    check_reg(A_CTL, 8'h05, "abort_busy");
`ifdef REFLET_VGA_CAPTURE_IRQ_EN
    check("irq_none_on_abort", 8'(irq_hi), 8'd1);
`endif
    check_pixel(8'd5, 8'd1, 8'h3D, "abort_row1_written");
    check_pixel(8'd5, 8'd2, 8'h05, "abort_row2_kept");
    back_porch();
    active_lines(0, 13, 6'h00);
    check_reg(A_CTL, 8'h06, "after_abort_done");
`ifdef REFLET_VGA_CAPTURE_IRQ_EN
    check("irq_hi_2", 8'(irq_hi), 8'd2);
`endif
    check_pixel(8'd5, 8'd1, 8'h0D, "recapture_row1");
    bus_write(A_CTL, 8'h06);
    check_reg(A_CTL, 8'h00, "flags_cleared");

    // 4. Reset in the middle of row 1, then a normal capture.
    bus_write(A_CTL, 8'h01);
    vsync_line();
    back_porch();
    active_lines(0, 3, 6'h30);
    vga_line(4, 6'h30, 1'b1, 3);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check_reg(A_CTL, 8'h00, "midreset_ctrl");
    check_reg(A_H,   8'h00, "midreset_h");
    check_reg(A_V,   8'h00, "midreset_v");
    check_reg(A_PIX, 8'h00, "midreset_mem_cleared");
    bus_write(A_CTL, 8'h01);
    vsync_line();
    back_porch();
    active_lines(0, 13, 6'h30);
    check_reg(A_CTL, 8'h02, "post_reset_done");
    check_pixel(8'd5, 8'd2, 8'h35, "post_reset_5_2");
    check_pixel(8'd5, 8'd1, 8'h3D, "post_reset_5_1");
    check_pixel(8'd0, 8'd3, 8'h38, "post_reset_0_3");

    // 5. Re-arm while busy, read-only PIXEL, out-of-range reads.
    bus_write(A_CTL, 8'h02);
    bus_write(A_CTL, 8'h01);
    vsync_line();
    back_porch();
    active_lines(0, 1, 6'h3F);
    bus_write(A_CTL, 8'h01);
    check_reg(A_CTL, 8'h01, "rearm_while_busy");
    active_lines(2, 13, 6'h3F);
    check_reg(A_CTL, 8'h02, "no_restart_done");
    check_pixel(8'd5, 8'd2, 8'h3A, "pix_before_ro_write");
    bus_write(A_PIX, 8'hFF);
    tick();
    check_reg(A_PIX, 8'h3A, "pixel_read_only");
    check_pixel(8'd7, 8'd3, 8'h30, "pix_last_corner");
    check_pixel(8'd9, 8'd0, 8'h00, "h_out_of_range");
    check_pixel(8'd0, 8'd4, 8'h00, "v_out_of_range");

`ifdef REFLET_VGA_CAPTURE_IRQ_EN
    // 6. One single-cycle pulse per completed frame, none for abort/reset.
    check("irq_hi_total", 8'(irq_hi), 8'd4);
    check("irq_rise_total", 8'(irq_rise), 8'd4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
